load_store_unit: RTL and testbench

- Memory-access stage directly upstream of data_memory. Accepts one load/store request at a time from the pipeline and sequences the data_memory control bus (DI, A, Size, RW, E).
- Supported accesses: byte, word and doubleword (two word beats).
- Performs sign/zero extension on loaded bytes and detects alignment and range faults before any memory access.
- Returns one response pulse per request.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data_memory control bus for load_store_unit.
// slave = the unit itself; master = the pipeline/memory side driving it.
interface load_store_unit_if #(parameter int ADDR_W = 8);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_fault;
    logic [63:0]       rsp_rdata;

    logic [31:0]       dm_di;
    logic [ADDR_W-1:0] dm_a;
    logic              dm_size;
    logic              dm_rw;
    logic              dm_e;
    logic [31:0]       dm_do;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, dm_do,
        output req_ready, rsp_valid, rsp_fault, rsp_rdata,
        output dm_di, dm_a, dm_size, dm_rw, dm_e
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, dm_do,
        input  req_ready, rsp_valid, rsp_fault, rsp_rdata,
        input  dm_di, dm_a, dm_size, dm_rw, dm_e
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer for data_memory: one request at a time, response pulse 1 cycle after a fault, 2 after a single beat, 3 after a doubleword.
// Backpressure: req_ready only in IDLE; no response backpressure, rsp_* must be taken in the pulse cycle.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    // Highest doubleword start address whose second beat stays inside memory.
    localparam logic [31:0] DW_MAX = 32'((1 << ADDR_W) - 8);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        fault;
    logic        store_q;
    logic        byte_q;
    logic        signed_q;
    logic        dword_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] rdata_lo_q;
    logic [31:0] load_word;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);
    assign load_word     = byte_q ? {{24{signed_q & bus.dm_do[7]}}, bus.dm_do[7:0]} : bus.dm_do;

    always_comb begin
        fault = 1'b0;
        if (bus.req_size == 2'b11)
            fault = 1'b1;
        if ((bus.req_size != 2'b00) && (bus.req_addr[1:0] != 2'b00))
            fault = 1'b1;
        if ((bus.req_size == 2'b10) && (32'(bus.req_addr) > DW_MAX))
            fault = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fault ? RESP : BEAT1;
            BEAT1:   state_nxt = dword_q ? BEAT2 : RESP;
            BEAT2:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dm_e      <= 1'b0;
            bus.dm_rw     <= 1'b0;
            bus.dm_size   <= 1'b0;
            bus.dm_a      <= '0;
            bus.dm_di     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= '0;
            store_q       <= 1'b0;
            byte_q        <= 1'b0;
            signed_q      <= 1'b0;
            dword_q       <= 1'b0;
            wdata_hi_q    <= '0;
            rdata_lo_q    <= '0;
        end else begin
            bus.rsp_valid <= (state_nxt == RESP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        store_q    <= bus.req_store;
                        byte_q     <= (bus.req_size == 2'b00);
                        signed_q   <= bus.req_signed;
                        dword_q    <= (bus.req_size == 2'b10);
                        wdata_hi_q <= bus.req_wdata[63:32];
                        bus.rsp_fault <= fault;
                        if (fault) begin
                            bus.rsp_rdata <= '0;
                        end else begin
                            bus.dm_a    <= bus.req_addr;
                            bus.dm_size <= (bus.req_size != 2'b00);
                            bus.dm_rw   <= bus.req_store;
                            bus.dm_e    <= bus.req_store;
                            if (bus.req_store)
                                bus.dm_di <= (bus.req_size == 2'b00) ?
                                             {24'b0, bus.req_wdata[7:0]} : bus.req_wdata[31:0];
                        end
                    end
                end
                BEAT1: begin
                    if (dword_q) begin
                        bus.dm_a   <= bus.dm_a + ADDR_W'(4);
                        bus.dm_rw  <= store_q;
                        bus.dm_e   <= store_q;
                        rdata_lo_q <= bus.dm_do;
                        if (store_q)
                            bus.dm_di <= wdata_hi_q;
                    end else begin
                        bus.dm_e      <= 1'b0;
                        bus.dm_rw     <= 1'b0;
                        bus.rsp_rdata <= store_q ? 64'b0 : {32'b0, load_word};
                    end
                end
                BEAT2: begin
                    bus.dm_e      <= 1'b0;
                    bus.dm_rw     <= 1'b0;
                    bus.rsp_rdata <= store_q ? 64'b0 : {bus.dm_do, rdata_lo_q};
                end
                default: begin
                    bus.dm_e  <= 1'b0;
                    bus.dm_rw <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array data_memory model and a strobe monitor.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;

    load_store_unit_if #(.ADDR_W(8)) bus();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          viol  = 0;
    logic [7:0]  mem [256];
    logic [7:0]  log_a [$];
    logic [31:0] log_d [$];
    logic        prev_e = 1'b0;
    logic [7:0]  prev_a = 8'd0;

    assign bus.dm_do = bus.dm_size ?
        {mem[8'(bus.dm_a + 8'd3)], mem[8'(bus.dm_a + 8'd2)], mem[8'(bus.dm_a + 8'd1)], mem[bus.dm_a]} :
        {24'h0, mem[bus.dm_a]};

    always @(posedge clk) begin
        if (bus.dm_e && bus.dm_rw) begin
            mem[bus.dm_a] <= bus.dm_di[7:0];
            if (bus.dm_size) begin
                mem[8'(bus.dm_a + 8'd1)] <= bus.dm_di[15:8];
                mem[8'(bus.dm_a + 8'd2)] <= bus.dm_di[23:16];
                mem[8'(bus.dm_a + 8'd3)] <= bus.dm_di[31:24];
            end
        end
        if (bus.dm_e) begin
            log_a.push_back(bus.dm_a);
            log_d.push_back(bus.dm_di);
            if (prev_e && (prev_a == bus.dm_a)) viol++;
        end
        prev_e = bus.dm_e;
        prev_a = bus.dm_a;
        if (bus.req_valid && bus.req_ready) n_acc++;
    end

    function automatic logic [31:0] rd32(input logic [7:0] a);
        return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
    endfunction

    // Presents one request, holds it across the accepting edge, returns in cycle T..T+1.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [7:0] ad, input logic [63:0] wd);
        @(negedge clk);
        bus.req_store = st; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = ad; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic f, output logic [63:0] d);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        f = bus.rsp_fault;
        d = bus.rsp_rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 8'd0; bus.req_wdata = 64'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.dm_e !== 1'b0) begin n_bad++; $display("FAIL rst_dm_e: got %0h want 0", bus.dm_e); end
        n_cmp++; if (bus.dm_rw !== 1'b0) begin n_bad++; $display("FAIL rst_dm_rw: got %0h want 0", bus.dm_rw); end
        n_cmp++; if (bus.dm_size !== 1'b0) begin n_bad++; $display("FAIL rst_dm_size: got %0h want 0", bus.dm_size); end
        n_cmp++; if (bus.dm_a !== 8'd0) begin n_bad++; $display("FAIL rst_dm_a: got %0h want 0", bus.dm_a); end
        n_cmp++; if (bus.dm_di !== 32'd0) begin n_bad++; $display("FAIL rst_dm_di: got %0h want 0", bus.dm_di); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0h want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_fault !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_fault: got %0h want 0", bus.rsp_fault); end
        n_cmp++; if (bus.rsp_rdata !== 64'd0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %0h want 0", bus.rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %0h want 1", bus.req_ready); end
    endtask

    task automatic test_word;
        int b; int lat; logic f; logic [63:0] d;
        b = log_a.size();
        do_req(1'b1, 2'b01, 1'b0, 8'd8, 64'h0000_0000_ABCD_EF01);
        n_cmp++; if (bus.dm_e !== 1'b1) begin n_bad++; $display("FAIL w_dm_e: got %0h want 1", bus.dm_e); end
        n_cmp++; if (bus.dm_a !== 8'd8) begin n_bad++; $display("FAIL w_dm_a: got %0h want 8", bus.dm_a); end
        n_cmp++; if (bus.dm_size !== 1'b1) begin n_bad++; $display("FAIL w_dm_size: got %0h want 1", bus.dm_size); end
        n_cmp++; if (bus.dm_rw !== 1'b1) begin n_bad++; $display("FAIL w_dm_rw: got %0h want 1", bus.dm_rw); end
        n_cmp++; if (bus.dm_di !== 32'hABCDEF01) begin n_bad++; $display("FAIL w_dm_di: got %0h want abcdef01", bus.dm_di); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL w_ready_beat: got %0h want 0", bus.req_ready); end
        wait_rsp(lat, f, d);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w_st_lat: got %0d want 1", lat); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL w_st_fault: got %0h want 0", f); end
        n_cmp++; if (d !== 64'd0) begin n_bad++; $display("FAIL w_st_rdata: got %0h want 0", d); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL w_pulse: got %0h want 0", bus.rsp_valid); end
        n_cmp++; if (bus.dm_e !== 1'b0) begin n_bad++; $display("FAIL w_dm_e_idle: got %0h want 0", bus.dm_e); end
        n_cmp++; if (log_a.size() - b !== 1) begin n_bad++; $display("FAIL w_strobes: got %0d want 1", log_a.size() - b); end
        do_req(1'b0, 2'b01, 1'b0, 8'd8, 64'd0);
        wait_rsp(lat, f, d);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w_ld_lat: got %0d want 1", lat); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL w_ld_fault: got %0h want 0", f); end
        n_cmp++; if (d !== 64'h0000_0000_ABCD_EF01) begin n_bad++; $display("FAIL w_ld_rdata: got %0h want abcdef01", d); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_rdata !== 64'h0000_0000_ABCD_EF01) begin n_bad++; $display("FAIL w_ld_hold: got %0h want abcdef01", bus.rsp_rdata); end
        n_cmp++; if (log_a.size() - b !== 1) begin n_bad++; $display("FAIL w_ld_strobes: got %0d want 1", log_a.size() - b); end
    endtask

    task automatic test_byte;
        int lat; logic f; logic [63:0] d;
        do_req(1'b1, 2'b00, 1'b0, 8'd0, 64'hFFFF_FFFF_1234_56A6);
        n_cmp++; if (bus.dm_di !== 32'h0000_00A6) begin n_bad++; $display("FAIL b_dm_di: got %0h want a6", bus.dm_di); end
        n_cmp++; if (bus.dm_size !== 1'b0) begin n_bad++; $display("FAIL b_dm_size: got %0h want 0", bus.dm_size); end
        wait_rsp(lat, f, d);
        do_req(1'b0, 2'b00, 1'b1, 8'd0, 64'd0);
        wait_rsp(lat, f, d);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b_s_lat: got %0d want 1", lat); end
        n_cmp++; if (d !== 64'h0000_0000_FFFF_FFA6) begin n_bad++; $display("FAIL b_signed: got %0h want ffffffa6", d); end
        do_req(1'b0, 2'b00, 1'b0, 8'd0, 64'd0);
        wait_rsp(lat, f, d);
        n_cmp++; if (d !== 64'h0000_0000_0000_00A6) begin n_bad++; $display("FAIL b_unsigned: got %0h want a6", d); end
    endtask

    task automatic test_dword;
        int b; int lat; logic f; logic [63:0] d;
        b = log_a.size();
        do_req(1'b1, 2'b10, 1'b0, 8'd16, 64'h5566_7788_1122_3344);
        wait_rsp(lat, f, d);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL d_st_lat: got %0d want 2", lat); end
        n_cmp++; if (log_a.size() - b !== 2) begin n_bad++; $display("FAIL d_strobes: got %0d want 2", log_a.size() - b); end
        n_cmp++; if (log_a[b] !== 8'd16 || log_d[b] !== 32'h11223344) begin n_bad++; $display("FAIL d_beat1: got a=%0d d=%0h want a=16 d=11223344", log_a[b], log_d[b]); end
        n_cmp++; if (log_a[b+1] !== 8'd20 || log_d[b+1] !== 32'h55667788) begin n_bad++; $display("FAIL d_beat2: got a=%0d d=%0h want a=20 d=55667788", log_a[b+1], log_d[b+1]); end
        do_req(1'b0, 2'b10, 1'b0, 8'd16, 64'd0);
        wait_rsp(lat, f, d);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL d_ld_lat: got %0d want 2", lat); end
        n_cmp++; if (d !== 64'h5566_7788_1122_3344) begin n_bad++; $display("FAIL d_ld_rdata: got %0h want 5566778811223344", d); end
        do_req(1'b1, 2'b10, 1'b0, 8'd248, 64'h0807_0605_0403_0201);
        wait_rsp(lat, f, d);
        n_cmp++; if (f !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL d_top_st: got fault=%0h lat=%0d want fault=0 lat=2", f, lat); end
        do_req(1'b0, 2'b10, 1'b0, 8'd248, 64'd0);
        wait_rsp(lat, f, d);
        n_cmp++; if (d !== 64'h0807_0605_0403_0201) begin n_bad++; $display("FAIL d_top_ld: got %0h want 0807060504030201", d); end
    endtask

    task automatic test_faults;
        logic [1:0] fs [3];
        logic [7:0] fa [3];
        int b; int lat; logic f; logic [63:0] d;
        fs = '{2'b01, 2'b10, 2'b11};
        fa = '{8'd6, 8'd252, 8'd12};
        for (int i = 0; i < 3; i++) begin
            b = log_a.size();
            do_req(1'b1, fs[i], 1'b0, fa[i], 64'hFFFF_FFFF_FFFF_FFFF);
            n_cmp++; if (bus.dm_e !== 1'b0) begin n_bad++; $display("FAIL f%0d_dm_e: got %0h want 0", i, bus.dm_e); end
            wait_rsp(lat, f, d);
            n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL f%0d_lat: got %0d want 0", i, lat); end
            n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL f%0d_fault: got %0h want 1", i, f); end
            n_cmp++; if (d !== 64'd0) begin n_bad++; $display("FAIL f%0d_rdata: got %0h want 0", i, d); end
            @(negedge clk);
            n_cmp++; if (log_a.size() - b !== 0) begin n_bad++; $display("FAIL f%0d_strobes: got %0d want 0", i, log_a.size() - b); end
        end
        n_cmp++; if (rd32(8'd252) !== 32'h08070605) begin n_bad++; $display("FAIL f_mem252: got %0h want 08070605", rd32(8'd252)); end
    endtask

    task automatic test_back_to_back;
        int b; int acc0;
        b = log_a.size();
        acc0 = n_acc;
        @(negedge clk);
        bus.req_store = 1'b1; bus.req_size = 2'b01; bus.req_signed = 1'b0;
        bus.req_addr = 8'd40; bus.req_wdata = 64'h0000_0000_0102_0304; bus.req_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bb_ready_beat: got %0h want 0", bus.req_ready); end
        n_cmp++; if (bus.dm_e !== 1'b1 || bus.dm_a !== 8'd40) begin n_bad++; $display("FAIL bb_st: got e=%0h a=%0d want e=1 a=40", bus.dm_e, bus.dm_a); end
        bus.req_store = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bb_resp: got v=%0h r=%0h want v=1 r=0", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bb_idle: got r=%0h v=%0h want r=1 v=0", bus.req_ready, bus.rsp_valid); end
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b0 || bus.dm_e !== 1'b0 || bus.dm_a !== 8'd40) begin n_bad++; $display("FAIL bb_ld_beat: got r=%0h e=%0h a=%0d want r=0 e=0 a=40", bus.req_ready, bus.dm_e, bus.dm_a); end
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'h0000_0000_0102_0304) begin n_bad++; $display("FAIL bb_ld_rsp: got v=%0h d=%0h want v=1 d=01020304", bus.rsp_valid, bus.rsp_rdata); end
        n_cmp++; if (n_acc - acc0 !== 2) begin n_bad++; $display("FAIL bb_accepts: got %0d want 2", n_acc - acc0); end
        n_cmp++; if (log_a.size() - b !== 1) begin n_bad++; $display("FAIL bb_strobes: got %0d want 1", log_a.size() - b); end
    endtask

    task automatic test_reset_mid;
        int b; int lat; logic f; logic [63:0] d; logic seen;
        do_req(1'b1, 2'b01, 1'b0, 8'd36, 64'h0000_0000_CAFE_F00D);
        wait_rsp(lat, f, d);
        b = log_a.size();
        do_req(1'b1, 2'b10, 1'b0, 8'd32, 64'h9999_9999_7777_7777);
        n_cmp++; if (bus.dm_e !== 1'b1 || bus.dm_a !== 8'd32) begin n_bad++; $display("FAIL rm_beat1: got e=%0h a=%0d want e=1 a=32", bus.dm_e, bus.dm_a); end
        @(posedge clk);
        #2;
        n_cmp++; if (bus.dm_e !== 1'b1 || bus.dm_a !== 8'd36) begin n_bad++; $display("FAIL rm_beat2: got e=%0h a=%0d want e=1 a=36", bus.dm_e, bus.dm_a); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.dm_e !== 1'b0) begin n_bad++; $display("FAIL rm_dm_e_async: got %0h want 0", bus.dm_e); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp: got %0h want 0", seen); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %0h want 1", bus.req_ready); end
        n_cmp++; if (rd32(8'd32) !== 32'h77777777) begin n_bad++; $display("FAIL rm_mem32: got %0h want 77777777", rd32(8'd32)); end
        n_cmp++; if (rd32(8'd36) !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rm_mem36: got %0h want cafef00d", rd32(8'd36)); end
        n_cmp++; if (log_a.size() - b !== 1) begin n_bad++; $display("FAIL rm_strobes: got %0d want 1", log_a.size() - b); end
    endtask

    task automatic test_strobe_rule;
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL strobe_rule: got %0d repeats want 0", viol); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_dword();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_strobe_rule();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
